// File: rtl/mac_serial_acc.sv
// Bit-serial multiply-accumulate back end: takes K serial products (LSB first),
// accumulates them modulo 2^N in a circular shift register and presents the sum.
module mac_serial_acc #(
    parameter int P = 16,
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0] P_LAST = BW'(P - 1);
    localparam logic [BW-1:0] N_LAST = BW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        EXT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [N-1:0]    acc, acc_next;
    logic            c, c_next;
    logic [BW-1:0]   bit_cnt, bit_next;
    logic [KW-1:0]   prod_cnt, prod_next;

    logic            process;
    logic            x;
    logic            last_bit;
    logic [1:0]      s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RECV;
            acc      <= '0;
            c        <= 1'b0;
            bit_cnt  <= '0;
            prod_cnt <= '0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            c        <= c_next;
            bit_cnt  <= bit_next;
            prod_cnt <= prod_next;
        end
    end

    // The accumulator rotates one full turn (N bits) per product, so after the
    // zero-extension bits it is aligned again with the LSB at bit 0.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        c_next     = c;
        bit_next   = bit_cnt;
        prod_next  = prod_cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        process    = 1'b0;
        x          = 1'b0;
        last_bit   = 1'b0;
        s          = 2'b00;

        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    process  = 1'b1;
                    x        = in_bit;
                    last_bit = (bit_cnt == P_LAST);
                end
            end
            EXT: begin
                process  = 1'b1;
                last_bit = (bit_cnt == N_LAST);
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) begin
                    acc_next   = '0;
                    prod_next  = '0;
                    state_next = RECV;
                end
            end
            default: state_next = RECV;
        endcase

        if (process) begin
            s        = {1'b0, x} + {1'b0, acc[0]} + {1'b0, c};
            acc_next = (acc >> 1) | (N'(s[0]) << (N - 1));
            c_next   = s[1];
            bit_next = bit_cnt + BW'(1);
            if (last_bit) begin
                if (state == RECV && N > P) begin
                    state_next = EXT;
                end else begin
                    // Carry out of bit N-1 is dropped: the sum wraps modulo 2^N.
                    c_next   = 1'b0;
                    bit_next = '0;
                    if (prod_cnt == K_LAST) begin
                        prod_next  = '0;
                        state_next = DONE;
                    end else begin
                        prod_next  = prod_cnt + KW'(1);
                        state_next = RECV;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mac_serial_acc.md
MAC_SERIAL_ACC -- requirements
Module: mac_serial_acc

Interface
REQ-001 Parameter: P, default 16, bit length of one serial product word (LSB first).
REQ-002 Parameter: N, default 32, accumulator width; legal only when N >= P.
REQ-003 Parameter: K, default 4, number of products summed per result; legal only when K >= 1.
REQ-004 Reset rst, asynchronous, active-high; clock clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  in_bit carries a product bit this cycle.
REQ-008 in_bit  input  1  serial product bit from the upstream bit-serial multiplier, LSB first.
REQ-009 in_ready  output  1  block accepts in_bit this cycle.
REQ-010 out_valid  output  1  out_data holds a completed K-product sum.
REQ-011 out_ready  input  1  downstream consumes out_data.
REQ-012 out_data  output  N  unsigned accumulated sum.

Function
REQ-013 The block SHALL implement three states: RECV, EXT and DONE.
REQ-014 The accumulator SHALL be an N-bit circular shift register acc with a 1-bit serial carry c, a bit counter (0..N-1) and a product counter (0..K-1).
REQ-015 A bit SHALL be accepted only when in_valid=1 and in_ready=1; no state SHALL change in RECV without an accepted bit.
REQ-016 Each processed bit x SHALL compute s = x + acc[0] + c, set acc <= {s[0], acc[N-1:1]} and set c <= s[1].
REQ-017 RECV: in_ready=1; each accepted bit is processed with x=in_bit and the bit counter increments.
REQ-018 On the P-th accepted bit, the next state SHALL be EXT if N > P, else end-of-product handling applies.
REQ-019 EXT: in_ready=0; one bit SHALL be processed per cycle with x=0 until N bits in total are processed for the product.
REQ-020 End of product: c SHALL clear to 0 (bit N discarded, sum modulo 2^N), the bit counter SHALL clear, and the product counter SHALL increment.
REQ-021 If the completed product is the K-th, the next state SHALL be DONE; otherwise it SHALL be RECV.
REQ-022 DONE: in_ready=0, out_valid=1, and out_data=acc (aligned, LSB at bit 0), stable until the handshake completes.
REQ-023 On out_valid and out_ready in DONE, the next cycle SHALL have acc=0, product counter=0, state RECV and out_valid=0.
REQ-024 out_data SHALL be 0 whenever out_valid=0.
REQ-025 Latency with no stalls: out_valid SHALL rise in the cycle following the K*N-th processing cycle after the first accepted bit.
REQ-026 in_bit SHALL be ignored when in_ready=0, regardless of in_valid.

Reset
REQ-027 rst SHALL force state RECV, acc=0, c=0 and both counters=0 immediately.
REQ-028 rst SHALL force in_ready=1, out_valid=0 and out_data=0 immediately.
REQ-029 Reset mid-product or in DONE SHALL discard all partial and pending results with no output produced.

Verification
REQ-030 P=4,N=8,K=1: bits 1,0,1,1 (13) back-to-back -> in_ready low cycles 5-8, out_valid high cycle 9, out_data=13.
REQ-031 P=4,N=8,K=2: products 5 and 3 -> out_data=8; then out_ready=1 -> acc cleared, in_ready=1 next cycle.
REQ-032 P=8,N=8,K=2: 200 then 100 -> out_data=44 (wrap modulo 256), no EXT cycles.
REQ-033 P=4,N=8,K=1: product 9 with in_valid toggled 1,0,0,1,... -> out_data=9, with the bit counter advancing only on accepted bits.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_data constant, and in_ready=0 with in_valid=1 has no effect.
REQ-035 rst after 2 bits of a product, then product 7 with K=1 -> out_data=7.
